// File: rtl/dsp_post_adder_acc_if.sv
// Bus bundle for the DSP48A1 post-adder/accumulator stage: clock enables, operands and results.
interface dsp_post_adder_acc_if #(
  parameter int PWIDTH = 48,
  parameter int MWIDTH = 36
);
  logic              ce_opmode;
  logic              ce_c;
  logic              ce_carryin;
  logic              ce_p;
  logic [4:0]        opmode;
  logic [MWIDTH-1:0] m_in;
  logic [PWIDTH-1:0] c_in;
  logic [PWIDTH-1:0] pcin;
  logic              carryin;
  logic [PWIDTH-1:0] p;
  logic [PWIDTH-1:0] pcout;
  logic              carryout;
  logic              ovf;

  modport master (
    output ce_opmode, ce_c, ce_carryin, ce_p, opmode, m_in, c_in, pcin, carryin,
    input  p, pcout, carryout, ovf
  );

  modport slave (
    input  ce_opmode, ce_c, ce_carryin, ce_p, opmode, m_in, c_in, pcin, carryin,
    output p, pcout, carryout, ovf
  );
endinterface

// File: rtl/dsp_post_adder_acc.sv
// DSP48A1 post-adder/accumulator: X/Z muxes, P = Z +/- (X + CIN), registered P/PCOUT/CARRYOUT.
// Optional sticky signed-overflow flag enabled by defining DSP_OVF_EN.
module dsp_post_adder_acc #(
  parameter int PWIDTH     = 48,
  parameter int MWIDTH     = 36,
  parameter int OPMODEREG  = 1,
  parameter int CREG       = 1,
  parameter int CARRYINREG = 1,
  parameter int PREG       = 1
) (
  input logic                clk,
  input logic                rst,
  dsp_post_adder_acc_if.slave bus
);

  logic [4:0]        opmode_d, opmode_q, opmode_s;
  logic [PWIDTH-1:0] c_d, c_q, c_s;
  logic              carryin_d, carryin_q, carryin_s;
  logic [PWIDTH-1:0] p_d, p_q;
  logic              carryout_d, carryout_q;
  logic [PWIDTH-1:0] p_fb_s, x_s, z_s;
  logic [PWIDTH:0]   s_s;

  always_comb begin
    opmode_d  = opmode_q;
    c_d       = c_q;
    carryin_d = carryin_q;
    if (bus.ce_opmode) opmode_d = bus.opmode;
    else               opmode_d = opmode_q;
    if (bus.ce_c) c_d = bus.c_in;
    else          c_d = c_q;
    if (bus.ce_carryin) carryin_d = bus.carryin;
    else                carryin_d = carryin_q;
  end

  assign opmode_s  = (OPMODEREG  != 0) ? opmode_q  : bus.opmode;
  assign c_s       = (CREG       != 0) ? c_q       : bus.c_in;
  assign carryin_s = (CARRYINREG != 0) ? carryin_q : bus.carryin;

  // Feedback only ever comes from the P flop, so PREG=0 reads as zero rather than a loop.
  assign p_fb_s = (PREG != 0) ? p_q : {PWIDTH{1'b0}};

  always_comb begin
    x_s = {PWIDTH{1'b0}};
    z_s = {PWIDTH{1'b0}};
    s_s = {(PWIDTH+1){1'b0}};
    case (opmode_s[1:0])
      2'd0:    x_s = {PWIDTH{1'b0}};
      2'd1:    x_s = {{(PWIDTH-MWIDTH){bus.m_in[MWIDTH-1]}}, bus.m_in};
      2'd2:    x_s = p_fb_s;
      2'd3:    x_s = c_s;
      default: x_s = {PWIDTH{1'b0}};
    endcase
    case (opmode_s[3:2])
      2'd0:    z_s = {PWIDTH{1'b0}};
      2'd1:    z_s = bus.pcin;
      2'd2:    z_s = p_fb_s;
      2'd3:    z_s = c_s;
      default: z_s = {PWIDTH{1'b0}};
    endcase
    if (opmode_s[4]) s_s = {1'b0, z_s} - ({1'b0, x_s} + {{PWIDTH{1'b0}}, carryin_s});
    else             s_s = {1'b0, z_s} + {1'b0, x_s} + {{PWIDTH{1'b0}}, carryin_s};
  end

  always_comb begin
    p_d        = p_q;
    carryout_d = carryout_q;
    if (bus.ce_p) begin
      p_d        = s_s[PWIDTH-1:0];
      carryout_d = s_s[PWIDTH];
    end else begin
      p_d        = p_q;
      carryout_d = carryout_q;
    end
  end

`ifdef DSP_OVF_EN
  logic              ovf_d, ovf_q;
  logic [PWIDTH-1:0] neg_x_s;
  logic              b_sign_s, ovf_evt_s, fresh_s;

  // Subtract compares against the sign of -X; a load not reading P restarts the sticky flag.
  always_comb begin
    neg_x_s   = {PWIDTH{1'b0}} - x_s;
    b_sign_s  = opmode_s[4] ? neg_x_s[PWIDTH-1] : x_s[PWIDTH-1];
    ovf_evt_s = (z_s[PWIDTH-1] == b_sign_s) && (s_s[PWIDTH-1] != z_s[PWIDTH-1]);
    fresh_s   = (opmode_s[1:0] != 2'd2) && (opmode_s[3:2] != 2'd2);
    ovf_d     = ovf_q;
    if (bus.ce_p) begin
      if (fresh_s) ovf_d = ovf_evt_s;
      else         ovf_d = ovf_q | ovf_evt_s;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign bus.ovf = (PREG != 0) ? ovf_q : ovf_d;
`else
  assign bus.ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opmode_q   <= 5'd0;
      c_q        <= {PWIDTH{1'b0}};
      carryin_q  <= 1'b0;
      p_q        <= {PWIDTH{1'b0}};
      carryout_q <= 1'b0;
    end else begin
      opmode_q   <= opmode_d;
      c_q        <= c_d;
      carryin_q  <= carryin_d;
      p_q        <= p_d;
      carryout_q <= carryout_d;
    end
  end

  assign bus.p        = (PREG != 0) ? p_q        : s_s[PWIDTH-1:0];
  assign bus.pcout    = bus.p;
  assign bus.carryout = (PREG != 0) ? carryout_q : s_s[PWIDTH];

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Self-checking bench for dsp_post_adder_acc: directed scenarios plus random traffic vs. an arithmetic model.
module tb_dsp_post_adder_acc;

  localparam logic [63:0] MASK48 = 64'h0000_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  dsp_post_adder_acc_if #(.PWIDTH(48), .MWIDTH(36)) bus ();

  dsp_post_adder_acc dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference state: input-stage registers and P/CARRYOUT/OVF as the block should hold them.
  logic [47:0] m_p;
  logic        m_co;
  logic        m_ovf;
  logic [4:0]  m_opm;
  logic [47:0] m_c;
  logic        m_cin;

  task automatic model_clear();
    m_p = 48'd0; m_co = 1'b0; m_ovf = 1'b0; m_opm = 5'd0; m_c = 48'd0; m_cin = 1'b0;
  endtask

  function automatic logic [63:0] pick(input logic [1:0] sel, input logic [63:0] alt);
    case (sel)
      2'd0:    pick = 64'd0;
      2'd1:    pick = alt;
      2'd2:    pick = {16'd0, m_p};
      default: pick = {16'd0, m_c};
    endcase
  endfunction

  task automatic tick();
    logic signed [63:0] mx;
    logic [63:0] x, z, s;
    logic [47:0] n_p, nx;
    logic        n_co, n_ovf, bsign;
    mx = 64'(signed'(bus.m_in));
    x  = pick(m_opm[1:0], mx & MASK48);
    z  = pick(m_opm[3:2], {16'd0, bus.pcin});
    if (m_opm[4]) s = z - (x + {63'd0, m_cin});
    else          s = z + x + {63'd0, m_cin};
    n_p = m_p; n_co = m_co; n_ovf = m_ovf;
    nx = 48'd0 - x[47:0];
    bsign = m_opm[4] ? nx[47] : x[47];
    if (bus.ce_p) begin
      n_p  = s[47:0];
      n_co = s[48];
`ifdef DSP_OVF_EN
      if (m_opm[1:0] != 2'd2 && m_opm[3:2] != 2'd2) n_ovf = 1'b0;
      if (z[47] == bsign && s[47] != z[47]) n_ovf = 1'b1;
`endif
    end
    @(posedge clk);
    #1;
    m_p = n_p; m_co = n_co; m_ovf = n_ovf;
    if (bus.ce_opmode)  m_opm = bus.opmode;
    if (bus.ce_c)       m_c   = bus.c_in;
    if (bus.ce_carryin) m_cin = bus.carryin;
  endtask

  task automatic drive_idle();
    bus.ce_opmode = 1'b1; bus.ce_c = 1'b1; bus.ce_carryin = 1'b1; bus.ce_p = 1'b1;
    bus.opmode = 5'd0; bus.m_in = 36'd0; bus.c_in = 48'd0; bus.pcin = 48'd0; bus.carryin = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if (bus.p !== 48'd0)      begin errors++; $display("FAIL reset_p got=%h want=0", bus.p); end
    if (bus.pcout !== 48'd0)  begin errors++; $display("FAIL reset_pcout got=%h want=0", bus.pcout); end
    if (bus.carryout !== 1'b0) begin errors++; $display("FAIL reset_carryout got=%b want=0", bus.carryout); end
    if (bus.ovf !== 1'b0)     begin errors++; $display("FAIL reset_ovf got=%b want=0", bus.ovf); end
  endtask

  task automatic test_accumulate();
    logic [47:0] want [4] = '{48'd5, 48'd10, 48'd15, 48'd20};
    do_reset();
    bus.opmode = 5'h09;
    bus.m_in   = 36'd5;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.p !== want[i] || bus.p !== m_p) begin
        errors++; $display("FAIL accum_step%0d got=%0d want=%0d", i, bus.p, want[i]);
      end
    end
    // Hold P while the new opmode is still captured.
    bus.ce_p   = 1'b0;
    bus.opmode = 5'h03;
    bus.c_in   = 48'd100;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.p !== 48'd20) begin errors++; $display("FAIL accum_hold%0d got=%0d want=20", i, bus.p); end
    end
    bus.ce_p = 1'b1;
    tick();
    checks++;
    if (bus.p !== 48'd100) begin errors++; $display("FAIL hold_then_load got=%0d want=100", bus.p); end
  endtask

  task automatic test_reset_mid_accumulate();
    do_reset();
    bus.opmode = 5'h09;
    bus.m_in   = 36'd5;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bus.p !== 48'd15) begin errors++; $display("FAIL midrst_pre got=%0d want=15", bus.p); end
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    checks += 3;
    if (bus.p !== 48'd0 || bus.pcout !== 48'd0) begin
      errors++; $display("FAIL async_rst_p got=%h/%h want=0", bus.p, bus.pcout);
    end
    if (bus.carryout !== 1'b0) begin errors++; $display("FAIL async_rst_co got=%b want=0", bus.carryout); end
    if (bus.ovf !== 1'b0)      begin errors++; $display("FAIL async_rst_ovf got=%b want=0", bus.ovf); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    checks++;
    if (bus.p !== 48'd0) begin errors++; $display("FAIL midrst_first got=%0d want=0", bus.p); end
    tick();
    checks++;
    if (bus.p !== 48'd5) begin errors++; $display("FAIL midrst_restart got=%0d want=5", bus.p); end
  endtask

  task automatic test_subtract_borrow();
    do_reset();
    bus.opmode = 5'h1D;
    bus.c_in   = 48'd3;
    bus.m_in   = 36'd5;
    bus.carryin = 1'b0;
    tick();
    tick();
    checks += 2;
    if (bus.p !== 48'hFFFF_FFFF_FFFE) begin errors++; $display("FAIL sub_p got=%h want=fffffffffffe", bus.p); end
    if (bus.carryout !== 1'b1) begin errors++; $display("FAIL sub_borrow got=%b want=1", bus.carryout); end
  endtask

  task automatic test_add_carry();
    do_reset();
    bus.opmode  = 5'h0F;
    bus.c_in    = 48'hFFFF_FFFF_FFFF;
    bus.carryin = 1'b1;
    tick();
    tick();
    checks += 2;
    if (bus.p !== 48'hFFFF_FFFF_FFFF) begin errors++; $display("FAIL add_p got=%h want=ffffffffffff", bus.p); end
    if (bus.carryout !== 1'b1) begin errors++; $display("FAIL add_carry got=%b want=1", bus.carryout); end
  endtask

`ifdef DSP_OVF_EN
  task automatic test_overflow();
    do_reset();
    bus.opmode = 5'h03;
    bus.c_in   = 48'h7FFF_FFFF_FFFF;
    tick();
    tick();
    bus.opmode = 5'h09;
    bus.m_in   = 36'd1;
    tick();
    tick();
    checks += 2;
    if (bus.p !== 48'h8000_0000_0000) begin errors++; $display("FAIL ovf_p got=%h want=800000000000", bus.p); end
    if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b want=1", bus.ovf); end
    bus.opmode = 5'h03;
    tick();
    checks++;
    if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b want=1", bus.ovf); end
    tick();
    checks++;
    if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b want=0", bus.ovf); end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 300; n++) begin
      bus.opmode     = 5'($urandom);
      bus.m_in       = {4'($urandom), 32'($urandom)};
      bus.c_in       = {16'($urandom), 32'($urandom)};
      bus.pcin       = {16'($urandom), 32'($urandom)};
      bus.carryin    = 1'($urandom);
      bus.ce_opmode  = ($urandom_range(0, 7) != 0);
      bus.ce_c       = ($urandom_range(0, 7) != 0);
      bus.ce_carryin = ($urandom_range(0, 7) != 0);
      bus.ce_p       = ($urandom_range(0, 7) != 0);
      tick();
      checks++;
      if (bus.p !== m_p || bus.pcout !== m_p || bus.carryout !== m_co || bus.ovf !== m_ovf) begin
        errors++;
        $display("FAIL random_%0d got p=%h pcout=%h co=%b ovf=%b want p=%h co=%b ovf=%b",
                 n, bus.p, bus.pcout, bus.carryout, bus.ovf, m_p, m_co, m_ovf);
      end
    end
  endtask

  initial begin
    drive_idle();
    model_clear();
    test_reset();
    test_accumulate();
    test_reset_mid_accumulate();
    test_subtract_borrow();
    test_add_carry();
`ifdef DSP_OVF_EN
    test_overflow();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
